mul_io_host: RTL

- Host-side driver for the 8-bit `io_in`/`io_out` pin interface of our multiplier tiles, the tile's counterpart.
- Generates the tile clock and tile reset, presents operands on `io_in`, and waits for the tile's ready bit or a fixed latency.
- Captures product/sign, checks them against an internal reference product, and returns the result through valid/ready.
- Used in the FPGA harness and in system benches in place of the cocotb driver.

---
 rtl/mul_io_pkg.sv | 42 ++++
 rtl/mul_io_if.sv | 30 +++
 rtl/mul_io_tclk_gen.sv | 41 ++++
 rtl/mul_io_host.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mul_io_pkg.sv
// Shared definitions for the multiplier-tile host: io pin indices, host
// states and the reference-product check used at capture time.
package mul_io_pkg;

  localparam int unsigned IO_CLK   = 0;
  localparam int unsigned IO_RST   = 1;
  localparam int unsigned IO_X_LSB = 2;
  localparam int unsigned IO_S     = 6;
  localparam int unsigned IO_RDY   = 7;

  typedef enum logic [1:0] {RESET, IDLE, WAIT, DONE} state_t;

  // Returns 1 when the observed tile word disagrees with x*y truncated to pw
  // bits. In signed mode operands are sign-extended and the sign pin must
  // equal the product MSB; otherwise the sign pin is ignored.
  function automatic logic ref_mismatch(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [31:0] obs,
                                        input int unsigned xw,
                                        input int unsigned yw,
                                        input int unsigned pw,
                                        input logic        sgn);
    logic [31:0] xm;
    logic [31:0] ym;
    logic [31:0] pmask;
    logic [31:0] prod;
    logic [31:0] p_obs;
    logic        s_ref;
    logic        s_obs;
    xm = x & ~(32'hFFFF_FFFF << xw);
    ym = y & ~(32'hFFFF_FFFF << yw);
    if (sgn && (((xm >> (xw - 1)) & 32'd1) != 32'd0)) xm = xm | (32'hFFFF_FFFF << xw);
    if (sgn && (((ym >> (yw - 1)) & 32'd1) != 32'd0)) ym = ym | (32'hFFFF_FFFF << yw);
    pmask = ~(32'hFFFF_FFFF << pw);
    prod  = (xm * ym) & pmask;
    p_obs = obs & pmask;
    s_ref = ((prod >> (pw - 1)) & 32'd1) != 32'd0;
    s_obs = ((obs >> IO_S) & 32'd1) != 32'd0;
    return (prod != p_obs) || (sgn && (s_ref != s_obs));
  endfunction

endpackage

// File: rtl/mul_io_if.sv
// Operand/result handshakes plus the 8-bit tile pin bus.
interface mul_io_if #(
  parameter int unsigned XW = 2,
  parameter int unsigned YW = 2,
  parameter int unsigned PW = 4
) ();
  logic          op_valid;
  logic          op_ready;
  logic [XW-1:0] op_x;
  logic [YW-1:0] op_y;
  logic [7:0]    io_in;
  logic [7:0]    io_out;
  logic          res_valid;
  logic          res_ready;
  logic [PW-1:0] res_p;
  logic          res_s;
  logic          res_timeout;
  logic          res_mismatch;
  logic          busy;

  modport master (
    input  op_valid, op_x, op_y, io_out, res_ready,
    output op_ready, io_in, res_valid, res_p, res_s, res_timeout, res_mismatch, busy
  );

  modport slave (
    output op_valid, op_x, op_y, io_out, res_ready,
    input  op_ready, io_in, res_valid, res_p, res_s, res_timeout, res_mismatch, busy
  );
endinterface

// File: rtl/mul_io_tclk_gen.sv
// Free-running tile clock divider. Strobes are asserted in the clk cycle whose
// closing edge toggles tclk, so logic using them updates on that same edge.
module mul_io_tclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tclk,
  output logic tile_rise,
  output logic tile_fall
);
  import mul_io_pkg::*;

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          tclk_q;
  logic          toggle;

  // Edge strobes decoded from the divider state.
  always_comb begin
    toggle    = (div_q == DW'(CLK_DIV - 1));
    tile_rise = toggle && !tclk_q;
    tile_fall = toggle && tclk_q;
    tclk      = tclk_q;
  end

  // Divider counter and tile clock register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tclk_q <= 1'b0;
    end else if (toggle) begin
      div_q  <= '0;
      tclk_q <= ~tclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/mul_io_host.sv
// Host-side driver for a multiplier tile: clocks and resets the tile, presents
// operands, waits for rdy / fixed latency / timeout, captures and checks the
// product and hands it back over a valid/ready result port.
module mul_io_host #(
  parameter int unsigned XW         = 2,
  parameter int unsigned YW         = 2,
  parameter int unsigned PW         = 4,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned USE_RDY    = 1,
  parameter int unsigned FIXED_LAT  = 1,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic      clk,
  input logic      rst_n,
  mul_io_if.master bus
);
  import mul_io_pkg::*;

  localparam int unsigned M1      = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int unsigned CNT_MAX = (M1 > FIXED_LAT) ? M1 : FIXED_LAT;
  localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RST_C = CW'(RST_CYCLES);
  localparam logic [CW-1:0] LAT_C = CW'(FIXED_LAT);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          trst_q;
  logic [PW-1:0] res_p_q;
  logic          res_s_q;
  logic          res_to_q;
  logic          res_mm_q;

  logic tclk, tile_rise, tile_fall;
  logic accept, to_hit, rdy_hit, capture, rst_done, mismatch;
  logic [7:0] io;

  mul_io_tclk_gen #(.CLK_DIV(CLK_DIV)) u_tclk (
    .clk       (clk),
    .rst_n     (rst_n),
    .tclk      (tclk),
    .tile_rise (tile_rise),
    .tile_fall (tile_fall)
  );

  // Event decode: accept, completion conditions and reference check.
  always_comb begin
    accept   = (state_q == IDLE) && bus.op_valid;
    to_hit   = (cnt_q == TO_C);
    rdy_hit  = (USE_RDY != 0) ? ((cnt_q != '0) && bus.io_out[IO_RDY]) : (cnt_q >= LAT_C);
    capture  = (state_q == WAIT) && tile_fall && (to_hit || rdy_hit);
    rst_done = (state_q == RESET) && tile_fall && (cnt_q >= RST_C);
    mismatch = ref_mismatch(32'(x_q), 32'(y_q), 32'(bus.io_out), XW, YW, PW, SIGNED != 0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET: if (rst_done)      state_d = IDLE;
      IDLE:  if (accept)        state_d = WAIT;
      WAIT:  if (capture)       state_d = DONE;
      DONE:  if (bus.res_ready) state_d = IDLE;
      default:                  state_d = RESET;
    endcase
  end

  // Saturating tile-rise counter, shared by the RESET and WAIT phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept || rst_done) begin
      cnt_q <= '0;
    end else if ((state_q == RESET || state_q == WAIT) && tile_rise && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Tile reset, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trst_q   <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      res_p_q  <= '0;
      res_s_q  <= 1'b0;
      res_to_q <= 1'b0;
      res_mm_q <= 1'b0;
    end else begin
      if (rst_done) trst_q <= 1'b0;
      if (accept) begin
        x_q <= bus.op_x;
        y_q <= bus.op_y;
      end
      if (capture) begin
        res_p_q  <= bus.io_out[PW-1:0];
        res_s_q  <= bus.io_out[IO_S];
        res_to_q <= to_hit;
        res_mm_q <= mismatch;
      end
    end
  end

  // Pin bus assembled purely from registers.
  always_comb begin
    io                    = '0;
    io[IO_CLK]            = tclk;
    io[IO_RST]            = trst_q;
    io[IO_X_LSB +: XW]    = x_q;
    io[IO_X_LSB+XW +: YW] = y_q;
  end

  assign bus.io_in        = io;
  assign bus.op_ready     = (state_q == IDLE);
  assign bus.res_valid    = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.res_p        = res_p_q;
  assign bus.res_s        = res_s_q;
  assign bus.res_timeout  = res_to_q;
  assign bus.res_mismatch = res_mm_q;

endmodule
